rect_copy_controller: RTL and testbench
=======================================

// Module: rect_copy_controller
// PURPOSE
//  Per-frame sequencer feeding the 64-rect gpu. On each frame_start it acquires the shared video RAM port, pulses
//  gpu_reset, issues copy_start, then streams 5 words per rect (x,y,w,h,color) on gpu_din in exactly the gpu copy
//  cadence (6 cycles/rect). Sits between the RAM arbiter and gpu; the CPU owns the RAM port when this block idles.
// PARAMETERS
//  RECT_COUNT        64   rects streamed per frame
//  RECT_COUNT_WIDTH  6    width of rect counter
//  ADDR_WIDTH        16   video RAM word-address width
// PORTS
//  clk          in   1           clock
//  reset        in   1           sync, active-high
//  frame_start  in   1           1-cycle pulse at start of vblank
//  rect_base    in   ADDR_WIDTH  RAM address of rect 0 word x; sampled on accepted frame_start
//  mem_req      out  1           request for RAM port
//  mem_gnt      in   1           grant; once given, held until mem_req drops
//  mem_addr     out  ADDR_WIDTH  RAM read address (sync RAM, data 1 cycle later)
//  mem_rdata    in   16          RAM read data
//  gpu_reset    out  1           reset to gpu (rewinds it to WAIT_FOR_COPY)
//  copy_start   out  1           gpu copy trigger
//  gpu_din      out  16          = mem_rdata (combinational pass-through)
//  busy         out  1           high from accepted frame_start until DONE
//  frame_done   out  1           1-cycle pulse after last color word
//  overrun      out  1           sticky: frame_start arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; mem_req=0, copy_start=0, busy=0, frame_done=0, overrun=0, mem_addr=0, gpu_reset=1.
//  gpu_reset = reset | internal registered pulse. All other outputs registered except gpu_din.
//  FSM: IDLE -> REQ -> GPU_RST -> START -> STREAM -> DONE -> IDLE.
//   IDLE: frame_start=1 -> latch rect_base into ptr, busy=1, go REQ.
//   REQ: mem_req=1; stay until mem_gnt=1 (checked same cycle), then GPU_RST.
//   GPU_RST: gpu_reset=1 for exactly this cycle.
//   START: copy_start=1 for exactly this cycle; phase=0, rect=0.
//   STREAM: phase counter 0..5 mirrors gpu copy_state (0=READ_START, 1..5=X,Y,W,H,COLOR).
//    mem_addr=ptr during phases 0..4, ptr++ each of those cycles; read data lands in phases 1..5.
//    phase 5: ptr not advanced; phase->0, rect++. rect==RECT_COUNT-1 && phase==5 -> DONE.
//   DONE: mem_req=0, busy=0, frame_done=1 (one cycle); -> IDLE.
//  mem_addr stride is 5 words/rect; ptr wraps mod 2^ADDR_WIDTH (no error).
//  mem_addr is don't-care outside REQ..STREAM, but must be held stable (no toggling).
//  frame_start while busy (any state but IDLE): ignored, overrun<=1. frame_start in DONE cycle: also overrun.
//  mem_gnt dropping mid-STREAM is an arbiter protocol violation; block does not stall (data is corrupt).
//  reset mid-frame: immediate IDLE, mem_req=0 next edge, gpu_reset held high; no frame_done.
//  Latency: frame_start@T0 with gnt already high -> REQ@T1, GPU_RST@T2, copy_start@T3, STREAM T4..T387, frame_done@T388.
// STRUCTURE
//  constants.svh: add RECT_WORDS=5, RECT_PHASES=6; state enum typedef in shared gpu package.
//  One sub-module natural: rect_addr_gen (ptr register, load/increment, phase+rect counters, last flag).
//  FSM + output regs in top; gpu_din a plain assign.
// TESTING
//  1 base=0x0100, gnt tied 1, RAM word k = k: frame_start@T0 -> copy_start@T3; gpu_din at T5..T9 = 0x100..0x104;
//    gpu rect_lefts[0]=0x100, rect_rights[0]=0x100+0x102; rect 63 color = 0x100+319; frame_done@T388.
//  2 gnt withheld 10 cycles: mem_req high throughout, gpu_reset/copy_start delayed exactly 10 cycles.
//  3 base=0xFFFE: mem_addr sequence 0xFFFE,0xFFFF,0x0000,...; no hang, frame_done still at T388.
//  4 frame_start at T100 mid-stream: ignored, overrun=1 and stays 1; stream and frame_done timing unchanged.
//  5 reset at T50: next cycle mem_req=0, busy=0, gpu_reset=1; no frame_done; new frame_start completes normally.
//  6 two back-to-back frames (second frame_start the cycle after frame_done): both complete, overrun stays 0,
//    gpu colors reflect second frame data.

Source files
------------

// File: rtl/rect_copy_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rect_copy_controller_pkg
//  Purpose  : Shared constants and state encoding for the per-frame rect
//             copy sequencer that feeds the 64-rect gpu.
//  Revision : 1.0 - initial release
// ============================================================================
package rect_copy_controller_pkg;

    localparam int RECT_COUNT       = 64;
    localparam int RECT_COUNT_WIDTH = 6;
    localparam int ADDR_WIDTH       = 16;
    localparam int DATA_WIDTH       = 16;

    // Words fetched per rect (x, y, w, h, color) and gpu cycles spent per rect
    // (one READ_START cycle plus one cycle per word).
    localparam int RECT_WORDS       = 5;
    localparam int RECT_PHASES      = RECT_WORDS + 1;
    localparam int PHASE_WIDTH      = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_GPU_RST = 3'd2,
        ST_START   = 3'd3,
        ST_STREAM  = 3'd4,
        ST_DONE    = 3'd5
    } rcc_state_t;

endpackage
`default_nettype wire

// File: rtl/rect_copy_controller_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : rect_copy_controller_addr_gen
//  Purpose  : Video RAM read pointer plus phase/rect counters that mirror the
//             gpu copy cadence. Flags the final phase of the final rect.
//  Revision : 1.0 - initial release
// ============================================================================
module rect_copy_controller_addr_gen
    import rect_copy_controller_pkg::*;
#(
    parameter int RECT_COUNT       = 64,
    parameter int RECT_COUNT_WIDTH = 6,
    parameter int ADDR_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic                  i_clear,
    input  logic                  i_step,
    output logic [ADDR_WIDTH-1:0] o_ptr,
    output logic                  o_last
);

    localparam logic [PHASE_WIDTH-1:0]      c_LAST_PHASE = PHASE_WIDTH'(RECT_PHASES - 1);
    localparam logic [RECT_COUNT_WIDTH-1:0] c_LAST_RECT  = RECT_COUNT_WIDTH'(RECT_COUNT - 1);

    logic [ADDR_WIDTH-1:0]       r_ptr;
    logic [PHASE_WIDTH-1:0]      r_phase;
    logic [RECT_COUNT_WIDTH-1:0] r_rect;

    // Pointer advances on the five word-address phases; the sixth phase only
    // rolls the phase counter over and bumps the rect index. Pointer wraps freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_phase <= '0;
            r_rect  <= '0;
        end else if (i_load) begin
            r_ptr   <= i_base;
            r_phase <= '0;
            r_rect  <= '0;
        end else if (i_clear) begin
            r_phase <= '0;
            r_rect  <= '0;
        end else if (i_step) begin
            if (r_phase == c_LAST_PHASE) begin
                r_phase <= '0;
                r_rect  <= r_rect + RECT_COUNT_WIDTH'(1);
            end else begin
                r_ptr   <= r_ptr + ADDR_WIDTH'(1);
                r_phase <= r_phase + PHASE_WIDTH'(1);
            end
        end
    end

    assign o_ptr  = r_ptr;
    assign o_last = (r_phase == c_LAST_PHASE) && (r_rect == c_LAST_RECT);

endmodule
`default_nettype wire

// File: rtl/rect_copy_controller.sv
`default_nettype none
// ============================================================================
//  Module   : rect_copy_controller
//  Purpose  : Per-frame sequencer: grabs the shared video RAM port, resets and
//             triggers the gpu, then streams 5 words per rect in gpu cadence.
//  Revision : 1.0 - initial release
// ============================================================================
module rect_copy_controller
    import rect_copy_controller_pkg::*;
#(
    parameter int RECT_COUNT       = 64,
    parameter int RECT_COUNT_WIDTH = 6,
    parameter int ADDR_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] rect_base,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_rdata,
    output logic                  gpu_reset,
    output logic                  copy_start,
    output logic [15:0]           gpu_din,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    rcc_state_t r_state;
    logic       r_mem_req;
    logic       r_gpu_rst_pulse;
    logic       r_copy_start;
    logic       r_busy;
    logic       r_frame_done;
    logic       r_overrun;

    logic       w_load;
    logic       w_clear;
    logic       w_step;
    logic       w_last;

    assign w_load  = (r_state == ST_IDLE) && frame_start;
    assign w_clear = (r_state == ST_START);
    assign w_step  = (r_state == ST_STREAM);

    rect_copy_controller_addr_gen #(
        .RECT_COUNT       (RECT_COUNT),
        .RECT_COUNT_WIDTH (RECT_COUNT_WIDTH),
        .ADDR_WIDTH       (ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_base  (rect_base),
        .i_clear (w_clear),
        .i_step  (w_step),
        .o_ptr   (mem_addr),
        .o_last  (w_last)
    );

    // Frame sequencer; each output register is set on the transition into the
    // state where it must be visible, so outputs line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_mem_req       <= 1'b0;
            r_gpu_rst_pulse <= 1'b0;
            r_copy_start    <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_gpu_rst_pulse <= 1'b0;
            r_copy_start    <= 1'b0;
            r_frame_done    <= 1'b0;
            // A new frame cannot be accepted until the DONE cycle has passed.
            if (frame_start && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state   <= ST_REQ;
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        r_state         <= ST_GPU_RST;
                        r_gpu_rst_pulse <= 1'b1;
                    end
                end
                ST_GPU_RST: begin
                    r_state      <= ST_START;
                    r_copy_start <= 1'b1;
                end
                ST_START: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_last) begin
                        r_state      <= ST_DONE;
                        r_mem_req    <= 1'b0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign gpu_reset  = reset | r_gpu_rst_pulse;
    assign copy_start = r_copy_start;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign gpu_din    = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rect_copy_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rect_copy_controller
//  Purpose  : Self-checking bench for rect_copy_controller with a timeline
//             model of each frame and a synchronous RAM stand-in.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rect_copy_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [15:0] rect_base;
    logic        mem_req;
    logic        mem_gnt;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        gpu_reset;
    logic        copy_start;
    logic [15:0] gpu_din;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;
    logic [15:0] ram_xor = 16'h0000;

    rect_copy_controller dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .rect_base   (rect_base),
        .mem_req     (mem_req),
        .mem_gnt     (mem_gnt),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .gpu_reset   (gpu_reset),
        .copy_start  (copy_start),
        .gpu_din     (gpu_din),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM content is a reversible function of the address so any word can be
    // predicted; ram_xor changes between frames to tell frames apart.
    function automatic logic [15:0] ramf(input logic [15:0] a);
        return a ^ ram_xor;
    endfunction

    always @(posedge clk) mem_rdata <= ramf(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    // A frame accepted at cycle t0 requests the port from t0+1; if the grant is
    // first seen at cycle g, the gpu reset is at g+1, copy_start at g+2, the
    // 384 stream cycles are g+3..g+386 and frame_done is at g+387.
    bit          m_active = 0;
    int          m_gnt_t  = -1;
    logic [15:0] m_base   = 16'h0;
    logic [15:0] m_held   = 16'h0;
    bit          m_ovr    = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            bit          granted;
            bit          done_now;
            bit          in_stream;
            int          k;
            int          r;
            int          ph;
            logic [15:0] e_addr;
            logic        e_req;
            granted   = m_active && (m_gnt_t >= 0);
            done_now  = granted && (cyc == m_gnt_t + 387);
            k         = granted ? cyc - (m_gnt_t + 3) : -1;
            in_stream = granted && (k >= 0) && (k < 384);
            r         = in_stream ? k / 6 : 0;
            ph        = in_stream ? k % 6 : 0;
            e_req     = m_active && !done_now;
            if (in_stream)      e_addr = m_base + 16'(5 * r + ph);
            else if (done_now)  e_addr = m_base + 16'd320;
            else if (m_active)  e_addr = m_base;
            else                e_addr = m_held;

            chk("mem_req",    {31'd0, mem_req},    {31'd0, e_req});
            chk("busy",       {31'd0, busy},       {31'd0, e_req});
            chk("gpu_reset",  {31'd0, gpu_reset},  {31'd0, reset | (granted && cyc == m_gnt_t + 1)});
            chk("copy_start", {31'd0, copy_start}, {31'd0, granted && cyc == m_gnt_t + 2});
            chk("frame_done", {31'd0, frame_done}, {31'd0, done_now});
            chk("overrun",    {31'd0, overrun},    {31'd0, m_ovr});
            chk("mem_addr",   {16'd0, mem_addr},   {16'd0, e_addr});
            if (in_stream && ph >= 1)
                chk("gpu_din", {16'd0, gpu_din}, {16'd0, ramf(m_base + 16'(5 * r + ph - 1))});

            // advance the model with this cycle's inputs
            if (reset) begin
                m_active = 0;
                m_gnt_t  = -1;
                m_held   = 16'h0;
                m_ovr    = 0;
            end else begin
                if (m_active && m_gnt_t < 0 && mem_gnt) m_gnt_t = cyc;
                if (frame_start) begin
                    if (m_active) m_ovr = 1;
                    else begin
                        m_active = 1;
                        m_gnt_t  = -1;
                        m_base   = rect_base;
                    end
                end
                if (done_now) begin
                    m_active = 0;
                    m_held   = m_base + 16'd320;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] cap_din  [0:9];
    logic [15:0] cap_addr [0:9];
    logic [15:0] cap_din387;

    // Launch one frame and follow it to frame_done (bounded). Reports
    // copy_start/frame_done cycles relative to the frame_start cycle.
    task automatic run_frame(input logic [15:0] base, input int gnt_delay,
                             input int spurious_at, output int t_copy, output int t_done);
        int t0;
        bit seen;
        t_copy = -1;
        t_done = -1;
        seen   = 0;
        @(posedge clk); #1;
        rect_base   = base;
        frame_start = 1'b1;
        if (gnt_delay > 0) mem_gnt = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (cyc - t0 < 10) begin
                cap_din[cyc - t0]  = gpu_din;
                cap_addr[cyc - t0] = mem_addr;
            end
            if (cyc - t0 == 387) cap_din387 = gpu_din;
            if (copy_start && t_copy < 0) t_copy = cyc - t0;
            if (frame_done) begin
                t_done = cyc - t0;
                seen   = 1;
            end else begin
                @(posedge clk); #1;
                frame_start = (spurious_at > 0) && (cyc - t0 == spurious_at);
                if (gnt_delay > 0 && cyc - t0 == gnt_delay + 1) mem_gnt = 1'b1;
            end
        end
        frame_start = 1'b0;
        mem_gnt     = 1'b1;
        if (!seen) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int tc, td, t0, nd;
        reset       = 1'b1;
        frame_start = 1'b0;
        rect_base   = 16'h0;
        mem_gnt     = 1'b1;
        @(posedge clk); #1;
        mon_en = 1;
        @(negedge clk);
        chk("rst_mem_req",    {31'd0, mem_req},    32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_copy_start", {31'd0, copy_start}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_overrun",    {31'd0, overrun},    32'd0);
        chk("rst_mem_addr",   {16'd0, mem_addr},   32'd0);
        chk("rst_gpu_reset",  {31'd0, gpu_reset},  32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1: base 0x0100, grant already high, RAM word k = k
        run_frame(16'h0100, 0, 0, tc, td);
        chk("t1_copy_start_at", tc, 32'd3);
        for (int i = 0; i < 5; i++)
            chk("t1_gpu_din", {16'd0, cap_din[5 + i]}, 32'h100 + i);
        chk("t1_rect63_color", {16'd0, cap_din387}, 32'h23F);
        chk("t1_frame_done_at", td, 32'd388);

        // 2: grant withheld for 10 cycles
        run_frame(16'h2000, 10, 0, tc, td);
        chk("t2_copy_start_at", tc, 32'd13);
        chk("t2_frame_done_at", td, 32'd398);

        // 3: pointer wraps through 0xFFFF
        run_frame(16'hFFFE, 0, 0, tc, td);
        chk("t3_addr0", {16'd0, cap_addr[4]}, 32'hFFFE);
        chk("t3_addr1", {16'd0, cap_addr[5]}, 32'hFFFF);
        chk("t3_addr2", {16'd0, cap_addr[6]}, 32'h0000);
        chk("t3_frame_done_at", td, 32'd388);

        // 4: frame_start mid-stream is ignored and flagged
        run_frame(16'h1234, 0, 100, tc, td);
        chk("t4_frame_done_at", td, 32'd388);
        chk("t4_overrun", {31'd0, overrun}, 32'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t4_overrun_sticky", {31'd0, overrun}, 32'd1);

        // 5: reset mid-frame
        @(posedge clk); #1;
        rect_base   = 16'h0300;
        frame_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        frame_start = 1'b0;
        while (cyc < t0 + 50) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_mem_req",   {31'd0, mem_req},   32'd0);
        chk("t5_busy",      {31'd0, busy},      32'd0);
        chk("t5_gpu_reset", {31'd0, gpu_reset}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_done) nd++;
        end
        chk("t5_no_frame_done", nd, 32'd0);
        run_frame(16'h0500, 0, 0, tc, td);
        chk("t5_after_frame_done_at", td, 32'd388);

        // 6: back-to-back frames with different RAM data
        ram_xor = 16'h5A5A;
        run_frame(16'h4000, 0, 0, tc, td);
        chk("t6a_frame_done_at", td, 32'd388);
        ram_xor = 16'hA5A5;
        run_frame(16'h8000, 0, 0, tc, td);
        chk("t6b_frame_done_at", td, 32'd388);
        chk("t6b_color0", {16'd0, cap_din[9]}, 32'h8004 ^ 32'hA5A5);
        chk("t6_overrun", {31'd0, overrun}, 32'd0);

        // randomized frames
        for (int n = 0; n < 6; n++) begin
            int d;
            int sp;
            d  = $urandom_range(0, 7);
            sp = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 380) : 0;
            ram_xor = 16'($urandom);
            run_frame(16'($urandom), d, sp, tc, td);
            chk("rnd_copy_start_at", tc, 32'(3 + d));
            chk("rnd_frame_done_at", td, 32'(388 + d));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
